// File: rtl/pad_frame_filt.sv
// pad_frame_filt: N_PADS bidirectional pad controller with registered output path,
// 2-flop input synchroniser and per-pad glitch filter. Edge IRQs built when PAD_FRAME_FILT_EDGE_IRQ_EN is defined.
module pad_frame_filt #(
    parameter int N_PADS = 32,
    parameter int CFG_W  = 6,
    parameter int FILT_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_PADS*CFG_W-1:0] pad_cfg_i,
    input  logic [FILT_W-1:0]       filt_len_i,
    input  logic [N_PADS-1:0]       oe_i,
    input  logic [N_PADS-1:0]       out_i,
    output logic [N_PADS-1:0]       in_o,
    output logic [N_PADS-1:0]       pad_oen_o,
    output logic [N_PADS-1:0]       pad_out_o,
    output logic [N_PADS-1:0]       pad_pen_o,
    input  logic [N_PADS-1:0]       pad_in_i,
    input  logic [N_PADS-1:0]       irq_clr_i,
    output logic [N_PADS-1:0]       irq_pending_o,
    output logic                    irq_o
);
    localparam int CFG_PULL     = 0;
    localparam int CFG_FILT     = 1;
    localparam int CFG_INV      = 2;
    localparam int CFG_FORCE_IN = 3;
    localparam int CFG_EDGE     = 4;

    function automatic logic [FILT_W-1:0] sat_inc(input logic [FILT_W-1:0] v);
        return (&v) ? v : v + FILT_W'(1);
    endfunction

    logic [N_PADS-1:0] sync_p0;
    logic [N_PADS-1:0] sync_p1;
    logic [N_PADS-1:0] stable_p2;
    logic [FILT_W-1:0] cnt_p2 [N_PADS];

    // output stage: one register between SoC mux and pad cell
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pad_oen_o <= '1;
            pad_out_o <= '0;
            pad_pen_o <= '1;
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                pad_oen_o[i] <= ~(oe_i[i] & ~pad_cfg_i[i*CFG_W + CFG_FORCE_IN]);
                pad_pen_o[i] <= ~pad_cfg_i[i*CFG_W + CFG_PULL];
            end
            pad_out_o <= out_i;
        end
    end

    // p0/p1: synchroniser (invert applied before the first flop)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            for (int i = 0; i < N_PADS; i++)
                sync_p0[i] <= pad_in_i[i] ^ pad_cfg_i[i*CFG_W + CFG_INV];
            sync_p1 <= sync_p0;
        end
    end

    // p2: glitch filter; ">=" lets a shrunken length complete on the next differing cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_p2 <= '0;
            for (int i = 0; i < N_PADS; i++)
                cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                if (!pad_cfg_i[i*CFG_W + CFG_FILT]) begin
                    stable_p2[i] <= sync_p1[i];
                    cnt_p2[i]    <= '0;
                end else if (sync_p1[i] == stable_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] >= filt_len_i) begin
                    stable_p2[i] <= sync_p1[i];
                    cnt_p2[i]    <= '0;
                end else begin
                    cnt_p2[i] <= sat_inc(cnt_p2[i]);
                end
            end
        end
    end

    assign in_o = stable_p2;

`ifdef PAD_FRAME_FILT_EDGE_IRQ_EN
    logic [N_PADS-1:0] prev_p3;
    logic [N_PADS-1:0] irq_pend_p3;
    logic [N_PADS-1:0] edge_hit;

    always_comb begin
        edge_hit = '0;
        for (int i = 0; i < N_PADS; i++)
            edge_hit[i] = (pad_cfg_i[i*CFG_W + CFG_EDGE]     &  stable_p2[i] & ~prev_p3[i]) |
                          (pad_cfg_i[i*CFG_W + CFG_EDGE + 1] & ~stable_p2[i] &  prev_p3[i]);
    end

    // p3: edge flags; a new edge outranks a simultaneous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_p3     <= '0;
            irq_pend_p3 <= '0;
        end else begin
            prev_p3     <= stable_p2;
            irq_pend_p3 <= (irq_pend_p3 & ~irq_clr_i) | edge_hit;
        end
    end

    assign irq_pending_o = irq_pend_p3;
    assign irq_o         = |irq_pend_p3;
`else
    assign irq_pending_o = '0;
    assign irq_o         = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{pad_cfg_i, irq_clr_i};

endmodule

// File: tb/tb_pad_frame_filt.sv
// Directed and scoreboard bench for pad_frame_filt; edge IRQ checks follow PAD_FRAME_FILT_EDGE_IRQ_EN.
`timescale 1ns/1ps
module tb_pad_frame_filt;
    localparam int N  = 32;
    localparam int CW = 6;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*CW-1:0] pad_cfg;
    logic [FW-1:0]   filt_len;
    logic [N-1:0]    oe, out_d, in_d, pad_oen, pad_out, pad_pen, pad_in, irq_clr, irq_pend;
    logic            irq;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pad_frame_filt #(.N_PADS(N), .CFG_W(CW), .FILT_W(FW)) dut (
        .clk_i(clk), .rst_i(rst), .pad_cfg_i(pad_cfg), .filt_len_i(filt_len),
        .oe_i(oe), .out_i(out_d), .in_o(in_d), .pad_oen_o(pad_oen),
        .pad_out_o(pad_out), .pad_pen_o(pad_pen), .pad_in_i(pad_in),
        .irq_clr_i(irq_clr), .irq_pending_o(irq_pend), .irq_o(irq)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int b, input logic v);
        pad_cfg[p*CW + b] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] m_s1, m_s2, m_stab;
    int           run [N];

    initial begin
        rst = 1'b1; pad_cfg = '0; filt_len = '0; oe = '0; out_d = '0;
        pad_in = '0; irq_clr = '0;
        #1;
        chk("rst_oen",  64'(pad_oen), 64'hFFFF_FFFF);
        chk("rst_out",  64'(pad_out), 64'h0);
        chk("rst_pen",  64'(pad_pen), 64'hFFFF_FFFF);
        chk("rst_in",   64'(in_d),    64'h0);
        chk("rst_irqp", 64'(irq_pend), 64'h0);
        chk("rst_irq",  64'(irq),     64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // output path and force-input
        oe[3] = 1'b1; out_d[3] = 1'b1;
        step(1);
        chk("oen3_on",  64'(pad_oen), 64'hFFFF_FFF7);
        chk("out3",     64'(pad_out), 64'h8);
        chk("pen_off",  64'(pad_pen), 64'hFFFF_FFFF);
        set_cfg(3, 3, 1'b1);
        set_cfg(4, 0, 1'b1);
        step(1);
        chk("oen3_frc", 64'(pad_oen), 64'hFFFF_FFFF);
        chk("pen4_on",  64'(pad_pen), 64'hFFFF_FFEF);

        // bypass latency and invert
        pad_in[0] = 1'b1;
        step(2); chk("byp_t2", 64'(in_d[0]), 64'h0);
        step(1); chk("byp_t3", 64'(in_d[0]), 64'h1);
        set_cfg(0, 2, 1'b1);
        step(2); chk("inv_t2", 64'(in_d[0]), 64'h1);
        step(1); chk("inv_t3", 64'(in_d[0]), 64'h0);
        pad_in[0] = 1'b0;
        step(3); chk("inv_lo", 64'(in_d[0]), 64'h1);
        set_cfg(0, 2, 1'b0);
        step(3); chk("inv_off", 64'(in_d[0]), 64'h0);

        // filter L=4 on pad 5
        filt_len = 4'd4;
        set_cfg(5, 1, 1'b1);
        step(2);
        pad_in[5] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step(1);
            if (n == 4) pad_in[5] = 1'b0;
            chk("f4_short", 64'(in_d[5]), 64'h0);
        end
        pad_in[5] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step(1);
            if (n == 5) pad_in[5] = 1'b0;
            chk($sformatf("f4_long_%0d", n), 64'(in_d[5]), (n >= 7 && n <= 11) ? 64'h1 : 64'h0);
        end

        // L=0 with filter on matches bypass latency
        filt_len = 4'd0;
        set_cfg(6, 1, 1'b1);
        step(1);
        pad_in[6] = 1'b1;
        step(2); chk("l0_t2", 64'(in_d[6]), 64'h0);
        step(1); chk("l0_t3", 64'(in_d[6]), 64'h1);

        // length shrink mid-count, then async reset mid-count
        pad_in = '0; pad_cfg = '0;
        do_reset();
        set_cfg(1, 1, 1'b1);
        filt_len = 4'd15;
        step(1);
        pad_in[1] = 1'b1;
        step(10); chk("l15_hold", 64'(in_d[1]), 64'h0);
        filt_len = 4'd2;
        step(1);  chk("l_shrink", 64'(in_d[1]), 64'h1);
        filt_len = 4'd15;
        pad_in[1] = 1'b0;
        step(6);  chk("l15_fall", 64'(in_d[1]), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in",  64'(in_d),    64'h0);
        chk("mid_rst_oen", 64'(pad_oen), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        rst = 1'b0;
        filt_len = 4'd2;
        pad_in[1] = 1'b1;
        step(4); chk("post_rst_t4", 64'(in_d[1]), 64'h0);
        step(1); chk("post_rst_t5", 64'(in_d[1]), 64'h1);

`ifdef PAD_FRAME_FILT_EDGE_IRQ_EN
        // rising-edge interrupt on pad 2
        pad_in = '0; pad_cfg = '0;
        do_reset();
        set_cfg(2, 4, 1'b1);
        step(2);
        pad_in[2] = 1'b1;
        step(3); chk("irq_t3", 64'(irq_pend), 64'h0);
        step(1); chk("irq_t4", 64'(irq_pend), 64'h4);
        chk("irq_or", 64'(irq), 64'h1);
        irq_clr[2] = 1'b1; step(1); irq_clr[2] = 1'b0;
        chk("irq_clr",  64'(irq_pend), 64'h0);
        chk("irq_or0",  64'(irq), 64'h0);
        pad_in[2] = 1'b0;
        step(5); chk("irq_fall_ign", 64'(irq_pend), 64'h0);
        pad_in[2] = 1'b1;
        step(4); chk("irq_rise2", 64'(irq_pend), 64'h4);
        pad_in[2] = 1'b0;
        step(4);
        pad_in[2] = 1'b1;
        step(3);
        irq_clr[2] = 1'b1; step(1); irq_clr[2] = 1'b0;
        chk("irq_set_wins", 64'(irq_pend), 64'h4);
        irq_clr[2] = 1'b1; step(1); irq_clr[2] = 1'b0;
        chk("irq_clr2", 64'(irq_pend), 64'h0);
`endif

        // all pads, independent random pulses, L=3, against a run-length model
        pad_in = '0; pad_cfg = '0;
        for (int p = 0; p < N; p++) set_cfg(p, 1, 1'b1);
        filt_len = 4'd3;
        do_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0;
        for (int p = 0; p < N; p++) run[p] = 0;
        for (int c = 0; c < 300; c++) begin
            pad_in = pad_in ^ ($urandom & $urandom & $urandom);
            @(posedge clk);
            for (int p = 0; p < N; p++) begin
                if (m_s2[p] != m_stab[p]) begin
                    run[p]++;
                    if (run[p] == 4) begin
                        m_stab[p] = m_s2[p];
                        run[p] = 0;
                    end
                end else begin
                    run[p] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = pad_in;
            #1;
            chk("rand_in", 64'(in_d), 64'(m_stab));
        end
        chk("rand_irqp", 64'(irq_pend), 64'h0);
        chk("rand_irq",  64'(irq), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
